// File: rtl/rng_ctrl_pkg.sv
// rng_ctrl_pkg: shared types and widths for the Trivium64 RNG bank
// reseed controller (state enum, seed/word widths, counter width).
package rng_ctrl_pkg;

    localparam int SEED_W = 80;
    localparam int WORD_W = 64;
    localparam int RC_W   = 16;

    typedef enum logic [2:0] {
        ST_SEED_WAIT = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WARMUP    = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4
    } state_e;

endpackage

// File: rtl/rng_mask_buf.sv
// rng_mask_buf: one-entry output register for mask words.
// Ports: load/din fill the entry, valid/ready/dout form the consumer side.
module rng_mask_buf #(
    parameter int W = 320
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/rng_reseed_ctrl.sv
// rng_reseed_ctrl: seeds the Trivium64 bank, waits out warm-up, streams
// one bank word per handshake and forces reseeds by count or request.
module rng_reseed_ctrl
    import rng_ctrl_pkg::*;
#(
    parameter int INSTANCES       = 5,
    parameter int RESEED_INTERVAL = 1024,
    parameter int WARMUP_TIMEOUT  = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        seed_valid,
    input  logic [INSTANCES*SEED_W-1:0] seed_data,
    output logic                        seed_ready,
    input  logic                        force_reseed,
    output logic                        rng_enable,
    output logic                        rng_reseed,
    output logic [INSTANCES*SEED_W-1:0] rng_seed,
    input  logic                        rng_is_ready,
    input  logic [INSTANCES*WORD_W-1:0] rng_random,
    output logic                        mask_valid,
    input  logic                        mask_ready,
    output logic [INSTANCES*WORD_W-1:0] mask_data,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [RC_W-1:0]             reseed_count
);

    localparam int SW = INSTANCES * SEED_W;
    localparam int RW = INSTANCES * WORD_W;
    localparam logic [16:0] INTERVAL = 17'(RESEED_INTERVAL);
    localparam logic [15:0] WU_LAST  = 16'(WARMUP_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [16:0]     word_cnt_q, word_cnt_d;
    logic [15:0]     warmup_cnt_q, warmup_cnt_d;
    logic            pend_q, pend_d;
    logic            timeout_err_q, timeout_err_d;
    logic [RC_W-1:0] reseed_count_q, reseed_count_d;
    logic [SW-1:0]   seed_q, seed_d;
    logic            seed_ready_q, seed_ready_d;
    logic            busy_q, busy_d;
    logic            load;

    // Take a new word only when the entry is free or leaving this cycle.
    assign load = (state_q == ST_RUN)
                && (!mask_valid || mask_ready)
                && (word_cnt_q < INTERVAL)
                && !pend_q;

    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        warmup_cnt_d   = warmup_cnt_q;
        pend_d         = pend_q;
        timeout_err_d  = timeout_err_q;
        reseed_count_d = reseed_count_q;
        seed_d         = seed_q;
        unique case (state_q)
            ST_SEED_WAIT: begin
                if (seed_valid && seed_ready_q) begin
                    seed_d        = seed_data;
                    timeout_err_d = 1'b0;
                    pend_d        = 1'b0;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                word_cnt_d   = '0;
                warmup_cnt_d = '0;
                pend_d       = 1'b0;
                if (reseed_count_q != '1) begin
                    reseed_count_d = reseed_count_q + 1'b1;
                end
                state_d = ST_WARMUP;
            end
            ST_WARMUP: begin
                warmup_cnt_d = warmup_cnt_q + 16'd1;
                if (rng_is_ready) begin
                    state_d = ST_RUN;
                end else if (warmup_cnt_q == WU_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_SEED_WAIT;
                end
            end
            ST_RUN: begin
                if (load) begin
                    word_cnt_d = word_cnt_q + 17'd1;
                end
                if (force_reseed) begin
                    pend_d = 1'b1;
                end
                if (word_cnt_q == INTERVAL || pend_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!mask_valid || mask_ready) begin
                    state_d = ST_SEED_WAIT;
                end
            end
            default: state_d = ST_SEED_WAIT;
        endcase
        // Moore outputs registered from the next state.
        seed_ready_d = (state_d == ST_SEED_WAIT);
        busy_d       = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_SEED_WAIT;
            word_cnt_q     <= '0;
            warmup_cnt_q   <= '0;
            pend_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            reseed_count_q <= '0;
            seed_q         <= '0;
            seed_ready_q   <= 1'b0;
            busy_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            warmup_cnt_q   <= warmup_cnt_d;
            pend_q         <= pend_d;
            timeout_err_q  <= timeout_err_d;
            reseed_count_q <= reseed_count_d;
            seed_q         <= seed_d;
            seed_ready_q   <= seed_ready_d;
            busy_q         <= busy_d;
        end
    end

    rng_mask_buf #(
        .W (RW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .din   (rng_random),
        .ready (mask_ready),
        .valid (mask_valid),
        .dout  (mask_data)
    );

    assign rng_reseed   = (state_q == ST_LOAD);
    assign rng_enable   = (state_q == ST_LOAD) || (state_q == ST_WARMUP) || load;
    assign rng_seed     = seed_q;
    assign seed_ready   = seed_ready_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign reseed_count = reseed_count_q;

endmodule

// File: doc/rng_reseed_ctrl.md
# rng_reseed_ctrl

Sequencing controller for the Trivium64 RNG bank that supplies fresh masking randomness to the masked cipher datapath. It accepts seeds from an external seed source, drives the bank's reseed/enable strobes, waits out keystream warm-up, and delivers one full bank word per valid/ready handshake to the mask consumer. It forces a reseed after a programmable number of delivered words or on request, and reports warm-up timeouts.

## Interface
- INSTANCES, 5: number of Trivium64 instances in the bank.
- RESEED_INTERVAL, 1024: words delivered per seed; range 1..65535.
- WARMUP_TIMEOUT, 4096: max WARMUP cycles before error; range 1..65535.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seed_valid  in  1  seed source has a seed.
- seed_data  in  INSTANCES*80  seeds, instance j at bits [(j+1)*80-1 -: 80].
- seed_ready  out  1  controller accepts a seed.
- force_reseed  in  1  single-cycle request to discard the current seed.
- rng_enable  out  1  bank enable; advances keystream one word per high cycle.
- rng_reseed  out  1  bank reseed strobe, exactly one cycle.
- rng_seed  out  INSTANCES*80  latched seed to the bank.
- rng_is_ready  in  1  bank isReady (instance 0).
- rng_random  in  INSTANCES*64  bank output word.
- mask_valid  out  1  mask_data holds an undelivered word.
- mask_ready  in  1  consumer accepts mask_data.
- mask_data  out  INSTANCES*64  randomness word.
- busy  out  1  high in every state except RUN.
- timeout_err  out  1  sticky warm-up timeout flag.
- reseed_count  out  16  number of LOAD entries, saturating at 65535.

## Operation
- States: SEED_WAIT, LOAD, WARMUP, RUN, DRAIN. Reset state is SEED_WAIT.
- SEED_WAIT: seed_ready=1. On seed_valid, latch seed_data into rng_seed, clear timeout_err, and go to LOAD.
- LOAD: rng_reseed=1 and rng_enable=1 for one cycle. Clear word_cnt and warmup_cnt. Increment reseed_count (saturating). Go to WARMUP.
- WARMUP: rng_enable=1 and warmup_cnt increments each cycle.
  - rng_is_ready=1 goes to RUN.
  - If warmup_cnt reaches WARMUP_TIMEOUT-1 without rng_is_ready, set timeout_err and go to SEED_WAIT.
  - If both occur in the same cycle, rng_is_ready wins.
- RUN: load condition L = (!mask_valid || mask_ready) && word_cnt < RESEED_INTERVAL && !pend.
  - When L holds: mask_data <= rng_random, mask_valid <= 1, rng_enable=1 in the same cycle, word_cnt++.
  - If mask_ready && mask_valid && !L, mask_valid <= 0.
  - Each keystream word is delivered at most once. A word is never skipped unless a reseed discards it.
- pend: set by force_reseed in RUN; cleared on LOAD entry. force_reseed in SEED_WAIT, LOAD or WARMUP is ignored.
- RUN exits to DRAIN when word_cnt==RESEED_INTERVAL or pend.
- DRAIN: rng_enable=0. Hold mask_data until handshake, then mask_valid <= 0 and go to SEED_WAIT. If mask_valid is already 0, go to SEED_WAIT the next cycle.
- rng_enable=0 in SEED_WAIT and DRAIN.
- mask_data is stable while mask_valid && !mask_ready.
- word_cnt is 17 bits so RESEED_INTERVAL=65535 cannot wrap.

## Timing
- Reset values: seed_ready=0 (goes to 1 in the first cycle after reset release), rng_enable=0, rng_reseed=0, rng_seed=0, mask_valid=0, mask_data=0, busy=1, timeout_err=0, reseed_count=0. All state registers clear.
- seed_ready and busy are Moore outputs. rng_enable and rng_reseed are decoded from state and the L term.
- Seed accepted at edge t. rng_reseed is high in cycle t+1. WARMUP starts at t+2.
- rng_is_ready sampled high in cycle w means RUN at w+1. First mask_valid at w+2.
- Sustained throughput: one word per cycle with mask_ready held high.
- force_reseed in cycle c with mask_ready=1: no new load from c+1. DRAIN delivers at most the one word already held.
- rst_n assertion mid-operation immediately clears mask_valid and all strobes, and discards the held word and seed.

## Structure
- Package rng_ctrl_pkg holds:
  - the state enum
  - SEED_W=80 and WORD_W=64
  - the reseed_count width of 16
- Sub-module rng_mask_buf: one-entry output register with load/valid/ready logic. The FSM, counters and pend flag stay in rng_reseed_ctrl.

## Test plan
- Reset and seed load: release reset, present seed_valid with seed 0x1234… on instance 0. Expect rng_reseed pulse 1 cycle after accept, rng_seed equal to the seed, and reseed_count=1.
- Warm-up then stream: model asserts rng_is_ready after 100 WARMUP cycles and mask_ready=1. Expect mask_valid 2 cycles later, then 1 word per cycle equal to the model keystream in order.
- Backpressure: mask_ready toggles 1,0,0,1. Expect mask_data held stable while stalled, rng_enable=0 on stall cycles, and no word lost or duplicated.
- Interval exhaustion: RESEED_INTERVAL=4. Expect exactly 4 words delivered, then DRAIN, then seed_ready=1, then reseed_count=2 after the next seed.
- force_reseed with mask_ready=0 and a word held: expect the held word delivered on the next handshake, then SEED_WAIT. A force_reseed pulse in WARMUP must have no effect.
- Timeout: rng_is_ready never rises with WARMUP_TIMEOUT=8. Expect timeout_err=1 after 8 WARMUP cycles and a return to SEED_WAIT. timeout_err clears on the next seed accept. An async rst_n pulse in RUN clears mask_valid within the same cycle.
